gpu_dispatch: RTL and testbench
===============================

Name: gpu_dispatch

Overview:
Parametrised command dispatcher and SRAM bus owner for the 2D GPU datapath. Pops commands from the instruction FIFO and decodes the opcode field. Each command goes to one of NUM_ENG engines (BLA, fill, alpha, …) over a start/done handshake. The shared SRAM port is granted exclusively to the engine running the current command, which removes multi-driver contention on the SRAM bus. Sits between the FIFO/config logic and the engine wrappers, replacing the fixed three-engine controller.

Parameters:
NUM_ENG, 3, number of engine channels; must be < 2**OP_W
CMD_W, 82, FIFO command width
OP_W, 2, opcode field width, taken from fifo_data[CMD_W-1 -: OP_W]
ADDR_W, 24, SRAM address width
DATA_W, 1536, SRAM write data width
CNT_W, 16, dispatched-command counter width
TIMEOUT_CYC, 4096, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
fifo_data  in  CMD_W  head-of-FIFO command (show-ahead, valid while !fifo_empty)
fifo_empty  in  1  FIFO empty flag
read_en  out  1  FIFO pop, one-cycle pulse
config_in  in  1  configuration request
config_done  in  1  configuration complete
config_en  out  1  configuration grant, held until config_done
eng_start  out  NUM_ENG  one-hot one-cycle start pulse per engine
eng_cmd  out  CMD_W  latched command, stable from start until done
eng_done  in  NUM_ENG  per-engine done pulse
eng_read_enable  in  NUM_ENG  per-engine SRAM read request
eng_write_enable  in  NUM_ENG  per-engine SRAM write request
eng_address  in  NUM_ENG*ADDR_W  flattened addresses; engine i uses slice [i*ADDR_W +: ADDR_W]
eng_write_data  in  NUM_ENG*DATA_W  flattened write data, same slicing rule
read_enable  out  1  SRAM read enable
write_enable  out  1  SRAM write enable
address  out  ADDR_W  SRAM address
write_data  out  DATA_W  SRAM write data
busy  out  1  high in any state other than IDLE
err_illegal  out  1  one-cycle pulse when an illegal opcode is dropped
timeout  out  1  one-cycle watchdog pulse; tied 0 when the feature is compiled out
cmd_count  out  CNT_W  count of commands dispatched to engines; wraps

Behaviour:
- Reset (asynchronous, any state): state = IDLE; cmd_reg = 0, owner = 0, cmd_count = 0. All outputs are 0 and the SRAM bus is released. Engines are not notified; they reset on the same n_rst.
- States:
  - IDLE:
    - config_in=1 → CONFIG. Config has priority over a non-empty FIFO in the same cycle.
    - else if !fifo_empty: read_en=1 (Mealy) and cmd_reg<=fifo_data in the same cycle → DISPATCH.
  - CONFIG: config_en=1 (Moore). config_done=1 → IDLE. The FIFO is not popped while in CONFIG.
  - DISPATCH: op = cmd_reg[CMD_W-1 -: OP_W].
    - op < NUM_ENG: eng_start[op]=1 for this cycle only; owner<=op; cmd_count<=cmd_count+1 (mod 2**CNT_W) → WAIT.
    - op == all-ones (NOP): no start, no count → IDLE.
    - otherwise: err_illegal=1 for one cycle → IDLE.
  - WAIT:
    - eng_done[owner]=1 → IDLE.
    - eng_done from any other engine is ignored.
- Latency: FIFO not empty in cycle t (IDLE) → read_en at t, eng_start at t+1. The earliest next pop is the cycle after done.
- eng_cmd = cmd_reg. It changes only on a pop.
- SRAM ownership (combinational mux):
  - In DISPATCH with a valid op, and in WAIT: outputs follow engine `owner`.
  - In all other states: read_enable = write_enable = 0, address = 0, write_data = 0.
  - Requests from non-owner engines are ignored.
  - If the owner asserts read and write together, write wins: write_enable=1 and read_enable is forced to 0.
- A done pulse that arrives in the same cycle as its own start is not possible: engines assert done no earlier than 1 cycle after start.

Optional Feature:
Macro DISPATCH_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYC-1 without eng_done[owner]: timeout=1 for one cycle, state → IDLE, SRAM bus released.
  - done in the same cycle as the limit is treated as normal completion, with no timeout.
- Undefined: no counter, timeout tied 0, WAIT never exits without done.

Decomposition:
- Package gpu_dispatch_pkg:
  - state enum (IDLE, CONFIG, DISPATCH, WAIT)
  - NOP opcode helper function (all-ones of OP_W)
  - opcode field position helper
- One sub-module, sram_owner_mux: parametrised NUM_ENG/ADDR_W/DATA_W. Handles owner select, release-to-zero and write-over-read priority.

Test Plan:
- FIFO holds op=1 command 0x1_2345 → read_en at t, eng_start=3'b010 at t+1, eng_cmd=0x1_2345. eng_done[1] at t+5 → busy=0 at t+6, cmd_count=1.
- config_in and !fifo_empty in the same cycle → config_en=1, read_en=0. After config_done → IDLE, then the FIFO pops.
- op=3 (NOP) → read_en pulse, no eng_start, cmd_count unchanged. With OP_W=3, op=5 → err_illegal pulse, back to IDLE.
- Owner=2 in WAIT with engine 0 requesting write at address 0x10: address follows engine 2 (0xABCDEF). Engine 2 asserts read+write → write_enable=1, read_enable=0. eng_done[0] in WAIT is ignored.
- n_rst low while in WAIT → all outputs 0 immediately; after release, the next command dispatches normally.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=8: no done → timeout pulse on the 8th WAIT cycle, bus released. cmd_count wraps 0xFFFF→0 on the next dispatch.

Source files
------------

// File: rtl/gpu_dispatch_pkg.sv
// gpu_dispatch_pkg: shared types and helpers for the GPU command dispatcher.
//   state_t    - dispatcher FSM states
//   op_lsb()   - bit position of the opcode field inside a command word
//   nop_opcode - all-ones opcode value for a given opcode width (the NOP)
package gpu_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONFIG   = 2'd1,
    DISPATCH = 2'd2,
    WAIT     = 2'd3
  } state_t;

  // The opcode occupies the top op_w bits of the command word.
  function automatic int op_lsb(input int cmd_w, input int op_w);
    return cmd_w - op_w;
  endfunction

  function automatic logic [31:0] nop_opcode(input int op_w);
    return (32'd1 << op_w) - 32'd1;
  endfunction

endpackage

// File: rtl/gpu_dispatch_sram_owner_mux.sv
// sram_owner_mux: steers the shared SRAM port to exactly one engine.
//   en                 - grant active; when low the bus is driven to all zeros
//   sel                - index of the engine that owns the bus
//   eng_read_enable    - per-engine read requests   (NUM_ENG)
//   eng_write_enable   - per-engine write requests  (NUM_ENG)
//   eng_address        - flattened addresses,  engine i at [i*ADDR_W +: ADDR_W]
//   eng_write_data     - flattened write data, engine i at [i*DATA_W +: DATA_W]
//   read_enable/write_enable/address/write_data - SRAM port
// A simultaneous read and write from the owner resolves to a write.
module sram_owner_mux
  import gpu_dispatch_pkg::*;
#(
  parameter int NUM_ENG = 3,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 1536,
  parameter int SEL_W   = 2
) (
  input  logic                        en,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_ENG-1:0]          eng_read_enable,
  input  logic [NUM_ENG-1:0]          eng_write_enable,
  input  logic [NUM_ENG*ADDR_W-1:0]   eng_address,
  input  logic [NUM_ENG*DATA_W-1:0]   eng_write_data,
  output logic                        read_enable,
  output logic                        write_enable,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           write_data
);

  always_comb begin
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    if (en) begin
      write_enable = eng_write_enable[sel];
      read_enable  = eng_read_enable[sel] & ~eng_write_enable[sel];
      address      = eng_address[sel*ADDR_W +: ADDR_W];
      write_data   = eng_write_data[sel*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/gpu_dispatch.sv
// gpu_dispatch: pops commands from the instruction FIFO, decodes the opcode
// and hands each command to one of NUM_ENG engines over a start/done
// handshake. The engine running the current command owns the SRAM port.
//
// Ports:
//   clk, n_rst             - clock, asynchronous active-low reset
//   fifo_data, fifo_empty  - show-ahead FIFO head; read_en pops it
//   config_in/config_done  - configuration request / completion; config_en grant
//   eng_start, eng_cmd     - one-hot start pulse and latched command to engines
//   eng_done               - per-engine completion pulse
//   eng_read_enable, eng_write_enable, eng_address, eng_write_data
//                          - per-engine SRAM requests (flattened buses)
//   read_enable, write_enable, address, write_data - shared SRAM port
//   busy                   - FSM not in IDLE
//   err_illegal            - pulse when an unknown opcode is dropped
//   timeout                - watchdog pulse (0 unless DISPATCH_TIMEOUT_EN)
//   cmd_count              - wrapping count of commands started on engines
//
// Build option: define DISPATCH_TIMEOUT_EN to add a WAIT-state watchdog that
// abandons a command after TIMEOUT_CYC cycles without the owner's done.
module gpu_dispatch
  import gpu_dispatch_pkg::*;
#(
  parameter int NUM_ENG     = 3,
  parameter int CMD_W       = 82,
  parameter int OP_W        = 2,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 1536,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [CMD_W-1:0]            fifo_data,
  input  logic                        fifo_empty,
  output logic                        read_en,
  input  logic                        config_in,
  input  logic                        config_done,
  output logic                        config_en,
  output logic [NUM_ENG-1:0]          eng_start,
  output logic [CMD_W-1:0]            eng_cmd,
  input  logic [NUM_ENG-1:0]          eng_done,
  input  logic [NUM_ENG-1:0]          eng_read_enable,
  input  logic [NUM_ENG-1:0]          eng_write_enable,
  input  logic [NUM_ENG*ADDR_W-1:0]   eng_address,
  input  logic [NUM_ENG*DATA_W-1:0]   eng_write_data,
  output logic                        read_enable,
  output logic                        write_enable,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           write_data,
  output logic                        busy,
  output logic                        err_illegal,
  output logic                        timeout,
  output logic [CNT_W-1:0]            cmd_count
);

  localparam int              OP_LSB = op_lsb(CMD_W, OP_W);
  localparam int              OWN_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(nop_opcode(OP_W));

  if (NUM_ENG >= (1 << OP_W)) begin : g_bad_num_eng
    $error("gpu_dispatch: NUM_ENG must be below 2**OP_W so the NOP opcode stays free");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("gpu_dispatch: TIMEOUT_CYC must be at least 2");
  end

  state_t           state, state_nxt;
  logic [CMD_W-1:0] cmd_reg;
  logic [OWN_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  op;
  logic             op_valid;
  logic             pop;
  logic             launch;
  logic             illegal;
  logic             done_own;
  logic             wd_expire;
  logic             bus_en;
  logic [OWN_W-1:0] bus_sel;

  assign op       = cmd_reg[OP_LSB +: OP_W];
  assign op_valid = (int'(op) < NUM_ENG);
  assign done_own = eng_done[owner];

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_cnt;

  // Cleared on the launch cycle so the first WAIT cycle sees 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
    end else if (launch) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // A done arriving on the limit cycle wins over the watchdog.
  assign wd_expire = (state == WAIT) && !done_own &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_reg <= '0;
      owner   <= '0;
      cnt     <= '0;
    end else begin
      if (pop) begin
        cmd_reg <= fifo_data;
      end
      if (launch) begin
        owner <= OWN_W'(op);
        cnt   <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    launch    = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: begin
        // Configuration takes priority over a waiting command.
        if (config_in) begin
          state_nxt = CONFIG;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = DISPATCH;
        end
      end
      CONFIG: begin
        if (config_done) begin
          state_nxt = IDLE;
        end
      end
      DISPATCH: begin
        state_nxt = IDLE;
        if (op_valid) begin
          launch    = 1'b1;
          state_nxt = WAIT;
        end else if (op != OP_NOP) begin
          illegal = 1'b1;
        end
      end
      WAIT: begin
        if (done_own || wd_expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // read_en is a Mealy output of IDLE; mask it so nothing pops while reset is held.
  assign read_en     = pop & n_rst;
  assign config_en   = (state == CONFIG);
  assign busy        = (state != IDLE);
  assign err_illegal = illegal;
  assign timeout     = wd_expire;
  assign eng_start   = launch ? (NUM_ENG'(1) << op) : '0;
  assign eng_cmd     = cmd_reg;
  assign cmd_count   = cnt;

  // During DISPATCH the owner register is not loaded yet, so select by opcode.
  assign bus_en  = launch || (state == WAIT);
  assign bus_sel = (state == DISPATCH) ? OWN_W'(op) : owner;

  sram_owner_mux #(
    .NUM_ENG (NUM_ENG),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SEL_W   (OWN_W)
  ) u_sram_owner_mux (
    .en               (bus_en),
    .sel              (bus_sel),
    .eng_read_enable  (eng_read_enable),
    .eng_write_enable (eng_write_enable),
    .eng_address      (eng_address),
    .eng_write_data   (eng_write_data),
    .read_enable      (read_enable),
    .write_enable     (write_enable),
    .address          (address),
    .write_data       (write_data)
  );

endmodule

// File: tb/tb_gpu_dispatch.sv
// Self-checking bench for gpu_dispatch. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, away from the rising (active) edge.
// Expected values come from a command-level reference model: opcode class,
// wrapping dispatch count and the bus-ownership rule.
module tb_gpu_dispatch;

  localparam int NE    = 3;
  localparam int CW    = 82;
  localparam int OW    = 3;
  localparam int AW    = 24;
  localparam int DW    = 64;
  localparam int CNTW  = 4;
  localparam int TOC   = 8;
  localparam int BUS_W = 2 + AW + DW;
  localparam int NOP   = (1 << OW) - 1;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic [CW-1:0]        fifo_data;
  logic                 fifo_empty;
  logic                 read_en;
  logic                 config_in;
  logic                 config_done;
  logic                 config_en;
  logic [NE-1:0]        eng_start;
  logic [CW-1:0]        eng_cmd;
  logic [NE-1:0]        eng_done;
  logic [NE-1:0]        eng_read_enable;
  logic [NE-1:0]        eng_write_enable;
  logic [NE*AW-1:0]     eng_address;
  logic [NE*DW-1:0]     eng_write_data;
  logic                 read_enable;
  logic                 write_enable;
  logic [AW-1:0]        address;
  logic [DW-1:0]        write_data;
  logic                 busy;
  logic                 err_illegal;
  logic                 timeout;
  logic [CNTW-1:0]      cmd_count;
  logic [BUS_W-1:0]     obs_bus;

  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  assign obs_bus = {write_enable, read_enable, address, write_data};

  gpu_dispatch #(
    .NUM_ENG(NE), .CMD_W(CW), .OP_W(OW), .ADDR_W(AW), .DATA_W(DW),
    .CNT_W(CNTW), .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .n_rst(n_rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .read_en(read_en), .config_in(config_in), .config_done(config_done),
    .config_en(config_en), .eng_start(eng_start), .eng_cmd(eng_cmd),
    .eng_done(eng_done), .eng_read_enable(eng_read_enable),
    .eng_write_enable(eng_write_enable), .eng_address(eng_address),
    .eng_write_data(eng_write_data), .read_enable(read_enable),
    .write_enable(write_enable), .address(address), .write_data(write_data),
    .busy(busy), .err_illegal(err_illegal), .timeout(timeout),
    .cmd_count(cmd_count)
  );

  // ---------------- reference model helpers ----------------
  function automatic logic [CW-1:0] make_cmd(input int op);
    logic [CW-OW-1:0] payload;
    payload = (CW-OW)'({$urandom, $urandom, $urandom});
    return {OW'(op), payload};
  endfunction

  // Owner's request with write-over-read; all zeros when nobody holds the bus.
  function automatic logic [BUS_W-1:0] model_bus(input int o, input bit granted);
    logic w, r;
    if (!granted) return '0;
    w = eng_write_enable[o];
    r = eng_read_enable[o] && !w;
    return {w, r, eng_address[o*AW +: AW], eng_write_data[o*DW +: DW]};
  endfunction

  task automatic rand_bus();
    eng_read_enable  = NE'($urandom);
    eng_write_enable = NE'($urandom);
    eng_address      = (NE*AW)'({$urandom, $urandom, $urandom});
    eng_write_data   = (NE*DW)'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  // One complete command through the FIFO, checked cycle by cycle.
  task automatic do_cmd(input logic [CW-1:0] cmd, input int dly, input string tag);
    int op;
    logic [NE-1:0] exp_start;
    logic exp_err;
    op = int'(cmd[CW-1 -: OW]);
    exp_start = (op < NE) ? NE'(1 << op) : '0;
    exp_err = (op >= NE) && (op != NOP);

    @(negedge clk); fifo_data = cmd; fifo_empty = 1'b0; rand_bus(); #1;
    tests++;
    if (read_en !== 1'b1 || eng_start !== '0 || obs_bus !== '0)
      begin fails++; $display("FAIL %s pop: read_en=%b eng_start=%b bus=%h, required read_en=1 start=0 bus=0", tag, read_en, eng_start, obs_bus); end

    @(negedge clk); fifo_empty = 1'b1; fifo_data = make_cmd(int'($urandom_range(0, NOP))); rand_bus(); #1;
    if (op < NE) exp_count = (exp_count + 1) % (1 << CNTW);
    tests++;
    if (eng_cmd !== cmd)
      begin fails++; $display("FAIL %s eng_cmd: got %h required %h", tag, eng_cmd, cmd); end
    tests++;
    if ({eng_start, err_illegal, read_en, busy} !== {exp_start, exp_err, 1'b0, 1'b1})
      begin fails++; $display("FAIL %s decode op=%0d: start=%b err=%b read_en=%b busy=%b, required start=%b err=%b read_en=0 busy=1", tag, op, eng_start, err_illegal, read_en, busy, exp_start, exp_err); end
    tests++;
    if (obs_bus !== model_bus(op, op < NE))
      begin fails++; $display("FAIL %s dispatch bus: got %h required %h", tag, obs_bus, model_bus(op, op < NE)); end

    if (op < NE) begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clk); rand_bus(); eng_done = NE'($urandom) & ~exp_start; #1;
        tests++;
        if ({busy, eng_start, err_illegal, timeout} !== {1'b1, {NE{1'b0}}, 1'b0, 1'b0} || obs_bus !== model_bus(op, 1'b1))
          begin fails++; $display("FAIL %s wait%0d: busy=%b start=%b to=%b bus=%h, required busy=1 start=0 to=0 bus=%h", tag, k, busy, eng_start, timeout, obs_bus, model_bus(op, 1'b1)); end
      end
      @(negedge clk); rand_bus(); eng_done = NE'($urandom) | exp_start; #1;
      tests++;
      if (busy !== 1'b1 || timeout !== 1'b0 || obs_bus !== model_bus(op, 1'b1))
        begin fails++; $display("FAIL %s done cycle: busy=%b to=%b bus=%h, required busy=1 to=0 bus=%h", tag, busy, timeout, obs_bus, model_bus(op, 1'b1)); end
    end

    @(negedge clk); eng_done = '0; rand_bus(); #1;
    tests++;
    if (busy !== 1'b0 || cmd_count !== CNTW'(exp_count) || obs_bus !== '0 || err_illegal !== 1'b0)
      begin fails++; $display("FAIL %s finish: busy=%b count=%0d bus=%h err=%b, required busy=0 count=%0d bus=0 err=0", tag, busy, cmd_count, obs_bus, err_illegal, exp_count); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst = 1'b0; fifo_empty = 1'b0; fifo_data = make_cmd(1);
    config_in = 1'b0; config_done = 1'b0; eng_done = '0; rand_bus();
    @(negedge clk); #1;
    tests++;
    if ({busy, read_en, config_en, eng_start, err_illegal, timeout} !== '0 || cmd_count !== '0 || eng_cmd !== '0 || obs_bus !== '0)
      begin fails++; $display("FAIL reset: busy=%b read_en=%b cfg=%b start=%b err=%b to=%b count=%0d cmd=%h bus=%h, required all 0", busy, read_en, config_en, eng_start, err_illegal, timeout, cmd_count, eng_cmd, obs_bus); end
    fifo_empty = 1'b1;
    @(negedge clk); n_rst = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_dispatch();
    logic [CW-1:0] c;
    c = {OW'(1), (CW-OW)'(20'h1_2345)};
    do_cmd(c, 3, "dispatch_op1");
    tests++;
    if (cmd_count !== CNTW'(1))
      begin fails++; $display("FAIL dispatch_count: got %0d required 1", cmd_count); end
  endtask

  task automatic test_config();
    logic [CW-1:0] c;
    c = make_cmd(2);
    @(negedge clk); config_in = 1'b1; fifo_empty = 1'b0; fifo_data = c; #1;
    tests++;
    if (read_en !== 1'b0 || config_en !== 1'b0)
      begin fails++; $display("FAIL config_prio: read_en=%b config_en=%b, required 0 0", read_en, config_en); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); config_in = 1'b0; #1;
      tests++;
      if (config_en !== 1'b1 || read_en !== 1'b0 || busy !== 1'b1)
        begin fails++; $display("FAIL config_hold%0d: config_en=%b read_en=%b busy=%b, required 1 0 1", k, config_en, read_en, busy); end
    end
    @(negedge clk); config_done = 1'b1; #1;
    tests++;
    if (config_en !== 1'b1 || read_en !== 1'b0)
      begin fails++; $display("FAIL config_done_cycle: config_en=%b read_en=%b, required 1 0", config_en, read_en); end
    @(negedge clk); config_done = 1'b0; #1;
    tests++;
    if (config_en !== 1'b0 || read_en !== 1'b1)
      begin fails++; $display("FAIL config_then_pop: config_en=%b read_en=%b, required 0 1", config_en, read_en); end
    @(negedge clk); fifo_empty = 1'b1; #1;
    exp_count = (exp_count + 1) % (1 << CNTW);
    tests++;
    if (eng_start !== 3'b100 || eng_cmd !== c)
      begin fails++; $display("FAIL config_dispatch: start=%b cmd=%h, required 100 %h", eng_start, eng_cmd, c); end
    @(negedge clk); eng_done = 3'b100; #1;
    @(negedge clk); eng_done = '0; #1;
    tests++;
    if (busy !== 1'b0 || cmd_count !== CNTW'(exp_count))
      begin fails++; $display("FAIL config_finish: busy=%b count=%0d, required 0 %0d", busy, cmd_count, exp_count); end
  endtask

  task automatic test_nop_illegal();
    do_cmd(make_cmd(NOP), 0, "nop");
    do_cmd(make_cmd(5), 0, "illegal5");
    do_cmd(make_cmd(3), 0, "illegal3");
  endtask

  task automatic test_ownership();
    @(negedge clk); fifo_empty = 1'b0; fifo_data = make_cmd(2);
    eng_read_enable = '0; eng_write_enable = '0; eng_address = '0; eng_write_data = '0; #1;
    @(negedge clk); fifo_empty = 1'b1; #1;
    exp_count = (exp_count + 1) % (1 << CNTW);
    @(negedge clk);
    eng_write_enable = 3'b001; eng_address[0 +: AW] = 24'h000010;
    eng_read_enable = 3'b100; eng_address[2*AW +: AW] = 24'hABCDEF;
    eng_write_data[2*DW +: DW] = 64'h5555_AAAA_1234_5678; #1;
    tests++;
    if (address !== 24'hABCDEF || read_enable !== 1'b1 || write_enable !== 1'b0)
      begin fails++; $display("FAIL own_addr: addr=%h re=%b we=%b, required abcdef 1 0", address, read_enable, write_enable); end
    @(negedge clk); eng_write_enable = 3'b101; #1;
    tests++;
    if (write_enable !== 1'b1 || read_enable !== 1'b0 || write_data !== 64'h5555_AAAA_1234_5678)
      begin fails++; $display("FAIL own_wr_prio: we=%b re=%b wd=%h, required 1 0 5555aaaa12345678", write_enable, read_enable, write_data); end
    @(negedge clk); eng_done = 3'b001; #1;
    @(negedge clk); eng_done = 3'b000; #1;
    tests++;
    if (busy !== 1'b1)
      begin fails++; $display("FAIL own_foreign_done: busy=%b, required 1", busy); end
    // Owner finishes while the next command already waits: no pop until the cycle after.
    @(negedge clk); eng_done = 3'b100; fifo_empty = 1'b0; fifo_data = make_cmd(NOP); #1;
    tests++;
    if (read_en !== 1'b0 || busy !== 1'b1)
      begin fails++; $display("FAIL own_done_nopop: read_en=%b busy=%b, required 0 1", read_en, busy); end
    @(negedge clk); eng_done = '0; #1;
    tests++;
    if (read_en !== 1'b1 || obs_bus !== '0)
      begin fails++; $display("FAIL back_to_back_pop: read_en=%b bus=%h, required 1 0", read_en, obs_bus); end
    @(negedge clk); fifo_empty = 1'b1; #1;
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0 || cmd_count !== CNTW'(exp_count) || eng_start !== '0)
      begin fails++; $display("FAIL back_to_back_nop: busy=%b count=%0d start=%b, required 0 %0d 000", busy, cmd_count, eng_start, exp_count); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk); fifo_empty = 1'b0; fifo_data = make_cmd(0); #1;
    @(negedge clk); fifo_empty = 1'b1; #1;
    @(negedge clk); rand_bus(); eng_write_enable = 3'b111; #1;
    @(negedge clk); n_rst = 1'b0; #1;
    exp_count = 0;
    tests++;
    if ({busy, eng_start, config_en, read_en} !== '0 || obs_bus !== '0 || cmd_count !== '0 || eng_cmd !== '0)
      begin fails++; $display("FAIL reset_in_wait: busy=%b start=%b bus=%h count=%0d cmd=%h, required all 0", busy, eng_start, obs_bus, cmd_count, eng_cmd); end
    @(negedge clk); n_rst = 1'b1;
    do_cmd(make_cmd(int'($urandom_range(0, NE-1))), 2, "after_reset");
  endtask

  task automatic test_watchdog();
`ifdef DISPATCH_TIMEOUT_EN
    @(negedge clk); fifo_empty = 1'b0; fifo_data = make_cmd(1); #1;
    @(negedge clk); fifo_empty = 1'b1; #1;
    exp_count = (exp_count + 1) % (1 << CNTW);
    for (int k = 1; k <= TOC; k++) begin
      @(negedge clk); rand_bus(); eng_write_enable = 3'b111; eng_done = NE'($urandom) & 3'b101; #1;
      tests++;
      if (timeout !== (k == TOC) || busy !== 1'b1)
        begin fails++; $display("FAIL timeout_cycle%0d: timeout=%b busy=%b, required %b 1", k, timeout, busy, (k == TOC)); end
    end
    @(negedge clk); eng_done = '0; #1;
    tests++;
    if (timeout !== 1'b0 || busy !== 1'b0 || obs_bus !== '0)
      begin fails++; $display("FAIL timeout_release: timeout=%b busy=%b bus=%h, required 0 0 0", timeout, busy, obs_bus); end
    // Done on the limit cycle counts as a normal completion.
    do_cmd(make_cmd(2), TOC - 1, "done_at_limit");
`else
    @(negedge clk); fifo_empty = 1'b0; fifo_data = make_cmd(1); #1;
    @(negedge clk); fifo_empty = 1'b1; #1;
    exp_count = (exp_count + 1) % (1 << CNTW);
    repeat (3 * TOC) @(negedge clk);
    #1;
    tests++;
    if (timeout !== 1'b0 || busy !== 1'b1)
      begin fails++; $display("FAIL no_watchdog: timeout=%b busy=%b, required 0 1", timeout, busy); end
    @(negedge clk); eng_done = 3'b010; #1;
    @(negedge clk); eng_done = '0; #1;
    tests++;
    if (busy !== 1'b0 || cmd_count !== CNTW'(exp_count))
      begin fails++; $display("FAIL no_watchdog_finish: busy=%b count=%0d, required 0 %0d", busy, cmd_count, exp_count); end
`endif
  endtask

  // Random mix; with a 4-bit counter this wraps cmd_count several times.
  task automatic test_random();
    int op;
    for (int n = 0; n < 48; n++) begin
      op = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, NE-1)) : int'($urandom_range(NE, NOP));
      do_cmd(make_cmd(op), int'($urandom_range(1, 5)), "random");
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk); rand_bus();
      end
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_config();
    test_nop_illegal();
    test_ownership();
    test_reset_in_wait();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion before 2000000");
    $fatal(1, "bench time limit reached");
  end

endmodule
